trip_control: RTL

//  Sequences the bike-computer distance datapath: conditions the raw reed switch into clean
//  one-cycle pulses, runs the trip state machine (IDLE/SETUP/RUN/PAUSE) driving the distance

---
 rtl/trip_control_pkg.sv | 35 +++
 rtl/trip_control_if.sv | 33 +++
 rtl/trip_control_reed_debounce.sv | 52 +++++
 rtl/trip_control.sv | 114 +++++++++++
 4 files changed

// File: rtl/trip_control_pkg.sv
// ============================================================================
// trip_control_pkg : shared trip-state encoding and wheel-circumference limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package trip_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } trip_state_t;

  localparam int CIRC_W = 8;
  localparam logic [CIRC_W-1:0] CIRC_DEFAULT = 8'd220;
  localparam logic [CIRC_W-1:0] CIRC_MIN     = 8'd100;
  localparam logic [CIRC_W-1:0] CIRC_MAX     = 8'd250;

  // One saturating step of the circumference, up or down.
  function automatic logic [CIRC_W-1:0] circ_step(input logic [CIRC_W-1:0] c,
                                                  input logic up);
    logic [CIRC_W-1:0] r;
    if (up) begin
      r = (c >= CIRC_MAX) ? CIRC_MAX : c + 8'd1;
    end else begin
      r = (c <= CIRC_MIN) ? CIRC_MIN : c - 8'd1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trip_control_if.sv
// ============================================================================
// trip_if : button/reed inputs and trip outputs of the bike-computer sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface trip_if;
  import trip_control_pkg::*;

  logic              reed_raw;
  logic              start_stop;
  logic              clear;
  logic              setup;
  logic              plus;
  logic              minus;
  logic              reed_pulse;
  logic              enable;
  logic              dist_reset;
  logic [CIRC_W-1:0] circ;
  trip_state_t       state;

  modport master (
    output reed_raw, start_stop, clear, setup, plus, minus,
    input  reed_pulse, enable, dist_reset, circ, state
  );

  modport slave (
    input  reed_raw, start_stop, clear, setup, plus, minus,
    output reed_pulse, enable, dist_reset, circ, state
  );
endinterface

`default_nettype wire

// File: rtl/trip_control_reed_debounce.sv
// ============================================================================
// reed_debounce : 2-FF synchronizer, level debouncer, rising-edge pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module reed_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  wire  logic clock,
  input  wire  logic reset,
  input  wire  logic reed_raw,
  output logic       reed_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      cnt        <= '0;
      reed_pulse <= 1'b0;
    end else begin
      sync1      <= reed_raw;
      sync2      <= sync1;
      level_d    <= level;
      reed_pulse <= level & ~level_d;
      // Any sample agreeing with the current level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/trip_control.sv
// ============================================================================
// trip_control : trip FSM, auto-pause timeout and circumference register
// Revision: 1.0
// ============================================================================
`default_nettype none

module trip_control
  import trip_control_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int STOP_TIMEOUT = 2000
) (
  input wire logic clock,
  input wire logic reset,
  trip_if.slave    bus
);

  localparam int TO_W = (STOP_TIMEOUT > 2) ? $clog2(STOP_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(STOP_TIMEOUT - 1);

  trip_state_t       state;
  logic [CIRC_W-1:0] circ;
  logic              enable;
  logic              dist_reset;
  logic [TO_W-1:0]   tcnt;
  logic              reed_pulse;
  logic              timeout_hit;

  reed_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_reed (
    .clock      (clock),
    .reset      (reset),
    .reed_raw   (bus.reed_raw),
    .reed_pulse (reed_pulse)
  );

  assign timeout_hit = (tcnt == TO_LAST) && !reed_pulse;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      circ       <= CIRC_DEFAULT;
      enable     <= 1'b0;
      dist_reset <= 1'b0;
      tcnt       <= '0;
    end else begin
      dist_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.clear) begin
            dist_reset <= 1'b1;
          end else if (bus.start_stop) begin
            state  <= ST_RUN;
            enable <= 1'b1;
            tcnt   <= '0;
          end else if (bus.setup) begin
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (bus.setup) begin
            state <= ST_IDLE;
          end else if (bus.plus) begin
            circ <= circ_step(circ, 1'b1);
          end else if (bus.minus) begin
            circ <= circ_step(circ, 1'b0);
          end
        end
        ST_RUN: begin
          // Counter saturates at its last value; a clear keeps us in RUN regardless.
          if (reed_pulse) begin
            tcnt <= '0;
          end else if (tcnt != TO_LAST) begin
            tcnt <= tcnt + 1'b1;
          end
          if (bus.clear) begin
            dist_reset <= 1'b1;
          end else if (bus.start_stop) begin
            state  <= ST_IDLE;
            enable <= 1'b0;
          end else if (timeout_hit) begin
            state  <= ST_PAUSE;
            enable <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (bus.clear) begin
            dist_reset <= 1'b1;
          end else if (bus.start_stop) begin
            state <= ST_IDLE;
          end else if (reed_pulse) begin
            state  <= ST_RUN;
            enable <= 1'b1;
            tcnt   <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          enable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state      = state;
  assign bus.circ       = circ;
  assign bus.enable     = enable;
  assign bus.dist_reset = dist_reset;
  assign bus.reed_pulse = reed_pulse;

endmodule

`default_nettype wire
